// File: rtl/acc_cpu_core.sv
// Multi-cycle accumulator CPU core with a ready-handshaked memory bus.
// Instructions run FETCH -> DECODE -> (LOAD | STORE | FETCH); bus outputs are decoded from state.
module acc_cpu_core #(
  parameter int          WIDTH    = 16,
  parameter int          A_WIDTH  = 8,
  parameter int unsigned RESET_PC = 0
) (
  input  logic               clk_in,
  input  logic               rst_in,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic [WIDTH-1:0]   mem_wdata,
  input  logic [WIDTH-1:0]   mem_rdata,
  input  logic               mem_ready,
  input  logic               resume,
  output logic               halt,
  output logic               zero,
  output logic               carry,
  output logic [A_WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0]   acc_out
);

  localparam logic [2:0] S_BOOT   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_LOAD   = 3'd3;
  localparam logic [2:0] S_STORE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  localparam logic [A_WIDTH-1:0] RESET_PC_A = A_WIDTH'(RESET_PC);
  localparam logic [A_WIDTH-1:0] PC_ONE     = A_WIDTH'(1);

  logic [2:0]         state;
  logic [2:0]         state_nxt;
  logic [A_WIDTH-1:0] pc;
  logic [A_WIDTH-1:0] pc_nxt;
  logic [WIDTH-1:0]   acc;
  logic [2:0]         ir_op;
  logic [A_WIDTH-1:0] ir_addr;
  logic [WIDTH:0]     alu_res;

  // Returns {carry, acc}; only ADD produces a new carry, the rest pass c_in through.
  function automatic logic [WIDTH:0] alu_exec(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b,
    input logic             c_in
  );
    logic [WIDTH:0] r;
    r = {c_in, a};
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_AND:  r = {c_in, a & b};
      OP_XOR:  r = {c_in, a ^ b};
      OP_LDA:  r = {c_in, b};
      default: r = {c_in, a};
    endcase
    return r;
  endfunction

  assign alu_res = alu_exec(ir_op, acc, mem_rdata, carry);

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      S_BOOT:  state_nxt = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          state_nxt = S_DECODE;
          pc_nxt    = pc + PC_ONE;
        end
      end
      S_DECODE: begin
        case (ir_op)
          OP_HLT: state_nxt = S_HALT;
          OP_SKZ: begin
            state_nxt = S_FETCH;
            if (zero) pc_nxt = pc + PC_ONE;
          end
          OP_JMP: begin
            state_nxt = S_FETCH;
            pc_nxt    = ir_addr;
          end
          OP_STO:  state_nxt = S_STORE;
          default: state_nxt = S_LOAD;
        endcase
      end
      S_LOAD, S_STORE: begin
        if (mem_ready) state_nxt = S_FETCH;
      end
      S_HALT: begin
        if (resume) state_nxt = S_FETCH;
      end
      default: state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state   <= S_BOOT;
      pc      <= RESET_PC_A;
      acc     <= '0;
      carry   <= 1'b0;
      ir_op   <= '0;
      ir_addr <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (state == S_FETCH && mem_ready) begin
        ir_op   <= mem_rdata[WIDTH-1 -: 3];
        ir_addr <= mem_rdata[A_WIDTH-1:0];
      end
      if (state == S_LOAD && mem_ready) begin
        {carry, acc} <= alu_res;
      end
    end
  end

  // Bus signals depend on state alone, so they hold steady across wait states
  // and drop immediately when reset forces the FSM back to BOOT.
  always_comb begin
    mem_rd   = 1'b0;
    mem_wr   = 1'b0;
    mem_addr = ir_addr;
    case (state)
      S_FETCH: begin
        mem_rd   = 1'b1;
        mem_addr = pc;
      end
      S_LOAD:  mem_rd = 1'b1;
      S_STORE: mem_wr = 1'b1;
      default: ;
    endcase
  end

  assign mem_wdata = acc;
  assign halt      = (state == S_HALT);
  assign zero      = (acc == '0);
  assign pc_out    = pc;
  assign acc_out   = acc;

endmodule
